lpif_txrx_gearbox: RTL

//  Parametrised LPIF <-> logic-link packer with rate gearing. Packs N LPIF slices (state/protid/data/dvalid/crc/crc_valid/valid)

---
 rtl/lpif_txrx_gearbox.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/lpif_txrx_gearbox.sv
// LPIF <-> logic-link packer with FULL/HALF rate gearing and valid/ready flow control on TX and RX.
// Optional build macro LPIF_GBX_ERRCNT_EN enables the saturating RX protocol-error counter.
module lpif_txrx_gearbox #(
  parameter int NUM_SLICE = 2,
  parameter int STATE_W   = 4,
  parameter int PROTID_W  = 2,
  parameter int DATA_W    = 512,
  parameter int CRC_W     = 16,
  localparam int SLICE_W  = STATE_W + PROTID_W + DATA_W + CRC_W + 3,
  localparam int FW       = NUM_SLICE * SLICE_W
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr,
  input  logic                          m_gen2_mode,
  input  logic [NUM_SLICE*STATE_W-1:0]  dstrm_state,
  input  logic [NUM_SLICE*PROTID_W-1:0] dstrm_protid,
  input  logic [NUM_SLICE*DATA_W-1:0]   dstrm_data,
  input  logic [NUM_SLICE-1:0]          dstrm_dvalid,
  input  logic [NUM_SLICE*CRC_W-1:0]    dstrm_crc,
  input  logic [NUM_SLICE-1:0]          dstrm_crc_valid,
  input  logic [NUM_SLICE-1:0]          dstrm_valid,
  input  logic                          dstrm_beat_vld,
  output logic                          dstrm_beat_rdy,
  output logic [FW-1:0]                 txfifo_downstream_data,
  output logic                          txfifo_downstream_vld,
  input  logic                          txfifo_downstream_rdy,
  input  logic [FW-1:0]                 rxfifo_upstream_data,
  input  logic                          rxfifo_upstream_vld,
  output logic                          rxfifo_upstream_rdy,
  output logic [NUM_SLICE*STATE_W-1:0]  ustrm_state,
  output logic [NUM_SLICE*PROTID_W-1:0] ustrm_protid,
  output logic [NUM_SLICE*DATA_W-1:0]   ustrm_data,
  output logic [NUM_SLICE-1:0]          ustrm_dvalid,
  output logic [NUM_SLICE*CRC_W-1:0]    ustrm_crc,
  output logic [NUM_SLICE-1:0]          ustrm_crc_valid,
  output logic [NUM_SLICE-1:0]          ustrm_valid,
  output logic                          ustrm_beat_vld,
  input  logic                          ustrm_beat_rdy,
  output logic [15:0]                   rx_err_cnt
);

  localparam int HALF_W   = (NUM_SLICE / 2) * SLICE_W;
  localparam int OFF_PROT = STATE_W;
  localparam int OFF_DATA = STATE_W + PROTID_W;
  localparam int OFF_DV   = OFF_DATA + DATA_W;
  localparam int OFF_CRC  = OFF_DV + 1;
  localparam int OFF_CV   = OFF_CRC + CRC_W;
  localparam int OFF_VLD  = SLICE_W - 1;

  typedef enum logic [1:0] {TX_EMPTY, TX_FULL, TX_HALF2} tx_state_e;
  typedef enum logic [1:0] {RX_EMPTY, RX_LOW, RX_FULL} rx_state_e;

  tx_state_e         tx_st_q, tx_st_d;
  rx_state_e         rx_st_q, rx_st_d;
  logic              mode_q, mode_d, mode_eff;
  logic [FW-1:0]     tx_word_q, tx_word_d;
  logic [HALF_W-1:0] tx_stage_q, tx_stage_d;
  logic              tx_vld_q, tx_vld_d;
  logic [FW-1:0]     rx_word_q, rx_word_d;
  logic              rx_vld_q, rx_vld_d;
  logic [FW-1:0]     dstrm_word;
  logic              tx_acc, rx_acc;

  // Mode may only change while both directions are idle, so a beat never changes gearing mid-flight.
  assign mode_eff = (tx_st_q == TX_EMPTY && rx_st_q == RX_EMPTY) ? m_gen2_mode : mode_q;
  assign mode_d   = mode_eff;

  always_comb begin
    dstrm_word = '0;
    for (int unsigned k = 0; k < NUM_SLICE; k++) begin
      dstrm_word[k*SLICE_W +: SLICE_W] = {dstrm_valid[k], dstrm_crc_valid[k],
        dstrm_crc[k*CRC_W +: CRC_W], dstrm_dvalid[k], dstrm_data[k*DATA_W +: DATA_W],
        dstrm_protid[k*PROTID_W +: PROTID_W], dstrm_state[k*STATE_W +: STATE_W]};
    end
  end

  always_comb begin
    tx_st_d        = tx_st_q;
    tx_word_d      = tx_word_q;
    tx_stage_d     = tx_stage_q;
    dstrm_beat_rdy = 1'b0;
    if (!rst_wr) begin
      case (tx_st_q)
        TX_EMPTY: dstrm_beat_rdy = 1'b1;
        TX_FULL:  dstrm_beat_rdy = mode_q && txfifo_downstream_rdy;
        default:  dstrm_beat_rdy = 1'b0;
      endcase
    end
    tx_acc = dstrm_beat_vld && dstrm_beat_rdy;
    case (tx_st_q)
      TX_EMPTY: if (tx_acc) begin
        tx_st_d = TX_FULL;
        if (mode_eff) begin
          tx_word_d = dstrm_word;
        end else begin
          tx_word_d  = {{HALF_W{1'b0}}, dstrm_word[HALF_W-1:0]};
          tx_stage_d = dstrm_word[FW-1:HALF_W];
        end
      end
      // In TX_FULL, mode_q is the mode the current beat was accepted in; HALF means a staged half is pending.
      TX_FULL: if (txfifo_downstream_rdy) begin
        if (!mode_q) begin
          tx_word_d = {{HALF_W{1'b0}}, tx_stage_q};
          tx_st_d   = TX_HALF2;
        end else if (tx_acc) begin
          tx_word_d = dstrm_word;
        end else begin
          tx_st_d = TX_EMPTY;
        end
      end
      TX_HALF2: if (txfifo_downstream_rdy) tx_st_d = TX_EMPTY;
      default:  tx_st_d = TX_EMPTY;
    endcase
    tx_vld_d = (tx_st_d != TX_EMPTY);
  end

  always_comb begin
    rx_st_d             = rx_st_q;
    rx_word_d           = rx_word_q;
    rxfifo_upstream_rdy = 1'b0;
    if (!rst_wr) begin
      case (rx_st_q)
        RX_EMPTY: rxfifo_upstream_rdy = 1'b1;
        RX_LOW:   rxfifo_upstream_rdy = 1'b1;
        RX_FULL:  rxfifo_upstream_rdy = mode_q && ustrm_beat_rdy;
        default:  rxfifo_upstream_rdy = 1'b0;
      endcase
    end
    rx_acc = rxfifo_upstream_vld && rxfifo_upstream_rdy;
    case (rx_st_q)
      RX_EMPTY: if (rx_acc) begin
        if (mode_eff) begin
          rx_word_d = rxfifo_upstream_data;
          rx_st_d   = RX_FULL;
        end else begin
          rx_word_d[HALF_W-1:0] = rxfifo_upstream_data[HALF_W-1:0];
          rx_st_d               = RX_LOW;
        end
      end
      RX_LOW: if (rx_acc) begin
        rx_word_d[FW-1:HALF_W] = rxfifo_upstream_data[HALF_W-1:0];
        rx_st_d                = RX_FULL;
      end
      RX_FULL: if (ustrm_beat_rdy) begin
        if (rx_acc) rx_word_d = rxfifo_upstream_data;
        else        rx_st_d   = RX_EMPTY;
      end
      default: rx_st_d = RX_EMPTY;
    endcase
    rx_vld_d = (rx_st_d == RX_FULL);
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      tx_st_q    <= TX_EMPTY;
      rx_st_q    <= RX_EMPTY;
      mode_q     <= 1'b0;
      tx_word_q  <= '0;
      tx_stage_q <= '0;
      tx_vld_q   <= 1'b0;
      rx_word_q  <= '0;
      rx_vld_q   <= 1'b0;
    end else begin
      tx_st_q    <= tx_st_d;
      rx_st_q    <= rx_st_d;
      mode_q     <= mode_d;
      tx_word_q  <= tx_word_d;
      tx_stage_q <= tx_stage_d;
      tx_vld_q   <= tx_vld_d;
      rx_word_q  <= rx_word_d;
      rx_vld_q   <= rx_vld_d;
    end
  end

  assign txfifo_downstream_data = tx_word_q;
  assign txfifo_downstream_vld  = tx_vld_q;
  assign ustrm_beat_vld         = rx_vld_q;

  always_comb begin
    ustrm_state     = '0;
    ustrm_protid    = '0;
    ustrm_data      = '0;
    ustrm_dvalid    = '0;
    ustrm_crc       = '0;
    ustrm_crc_valid = '0;
    ustrm_valid     = '0;
    for (int unsigned k = 0; k < NUM_SLICE; k++) begin
      ustrm_state[k*STATE_W +: STATE_W]    = rx_word_q[k*SLICE_W +: STATE_W];
      ustrm_protid[k*PROTID_W +: PROTID_W] = rx_word_q[k*SLICE_W + OFF_PROT +: PROTID_W];
      ustrm_data[k*DATA_W +: DATA_W]       = rx_word_q[k*SLICE_W + OFF_DATA +: DATA_W];
      ustrm_dvalid[k]                      = rx_word_q[k*SLICE_W + OFF_DV];
      ustrm_crc[k*CRC_W +: CRC_W]          = rx_word_q[k*SLICE_W + OFF_CRC +: CRC_W];
      ustrm_crc_valid[k]                   = rx_word_q[k*SLICE_W + OFF_CV];
      ustrm_valid[k]                       = rx_word_q[k*SLICE_W + OFF_VLD];
    end
  end

`ifdef LPIF_GBX_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d, err_inc;
  logic [16:0] err_sum;

  // Only the low-half slices carry data in HALF mode; the upper half of the word is ignored.
  always_comb begin
    err_inc = '0;
    if (rx_acc) begin
      for (int unsigned k = 0; k < NUM_SLICE; k++) begin
        if ((k < NUM_SLICE / 2 || mode_eff) && rxfifo_upstream_data[k*SLICE_W + OFF_DV]
            && !rxfifo_upstream_data[k*SLICE_W + OFF_VLD])
          err_inc = err_inc + 16'd1;
      end
    end
    err_sum   = {1'b0, err_cnt_q} + {1'b0, err_inc};
    err_cnt_d = err_sum[16] ? '1 : err_sum[15:0];
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign rx_err_cnt = err_cnt_q;
`else
  assign rx_err_cnt = '0;
`endif

endmodule
